// File: rtl/ps2_command_buffer.sv
// PS/2 set-2 scan-code to ASCII command-line assembler with backspace/escape/enter
// editing and a valid/ready commit handshake. Optional macro PS2_SHIFT_EN adds shift tracking.
module ps2_command_buffer #(
    parameter int DEPTH = 4,
    parameter int LEN_W = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 key_valid,
    input  logic [7:0]           key_code,
    input  logic                 cmd_ready,
    output logic                 cmd_valid,
    output logic [8*DEPTH-1:0]   cmd_data,
    output logic [LEN_W-1:0]     cmd_len,
    output logic                 overflow,
    output logic [7:0]           last_char
);

    typedef enum logic {COLLECT, HOLD} mode_t;
    // Break/extended prefix tracking lives apart from mode so releases spanning a handshake are filtered.
    typedef enum logic [1:0] {PFX_NONE, PFX_BREAK, PFX_EXT} prefix_t;

    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BKSP  = 8'h66;
    localparam logic [7:0] CODE_ESC   = 8'h76;
    localparam logic [7:0] CODE_ENTER = 8'h5A;

    mode_t                mode, mode_n;
    prefix_t              prefix, prefix_n;
    logic [8*DEPTH-1:0]   data_n;
    logic [LEN_W-1:0]     len_n;
    logic                 ovf_n;
    logic [7:0]           last_n;
    logic [8:0]           dec;
    logic [7:0]           ascii;
`ifdef PS2_SHIFT_EN
    logic                 shift_held, shift_n;
`endif

    // Returns {printable, uppercase ascii}.
    function automatic logic [8:0] decode(input logic [7:0] code);
        logic [8:0] r;
        r = 9'h000;
        case (code)
            8'h1C: r = {1'b1, 8'h41}; 8'h32: r = {1'b1, 8'h42}; 8'h21: r = {1'b1, 8'h43};
            8'h23: r = {1'b1, 8'h44}; 8'h24: r = {1'b1, 8'h45}; 8'h2B: r = {1'b1, 8'h46};
            8'h34: r = {1'b1, 8'h47}; 8'h33: r = {1'b1, 8'h48}; 8'h43: r = {1'b1, 8'h49};
            8'h3B: r = {1'b1, 8'h4A}; 8'h42: r = {1'b1, 8'h4B}; 8'h4B: r = {1'b1, 8'h4C};
            8'h3A: r = {1'b1, 8'h4D}; 8'h31: r = {1'b1, 8'h4E}; 8'h44: r = {1'b1, 8'h4F};
            8'h4D: r = {1'b1, 8'h50}; 8'h15: r = {1'b1, 8'h51}; 8'h2D: r = {1'b1, 8'h52};
            8'h1B: r = {1'b1, 8'h53}; 8'h2C: r = {1'b1, 8'h54}; 8'h3C: r = {1'b1, 8'h55};
            8'h2A: r = {1'b1, 8'h56}; 8'h1D: r = {1'b1, 8'h57}; 8'h22: r = {1'b1, 8'h58};
            8'h35: r = {1'b1, 8'h59}; 8'h1A: r = {1'b1, 8'h5A};
            8'h45: r = {1'b1, 8'h30}; 8'h16: r = {1'b1, 8'h31}; 8'h1E: r = {1'b1, 8'h32};
            8'h26: r = {1'b1, 8'h33}; 8'h25: r = {1'b1, 8'h34}; 8'h2E: r = {1'b1, 8'h35};
            8'h36: r = {1'b1, 8'h36}; 8'h3D: r = {1'b1, 8'h37}; 8'h3E: r = {1'b1, 8'h38};
            8'h46: r = {1'b1, 8'h39};
            8'h29: r = {1'b1, 8'h20};
            default: r = 9'h000;
        endcase
        return r;
    endfunction

    assign cmd_valid = (mode == HOLD);
    assign dec       = decode(key_code);

    always_comb begin
        ascii = dec[7:0];
`ifdef PS2_SHIFT_EN
        if (!shift_held && ascii >= 8'h41 && ascii <= 8'h5A)
            ascii = ascii | 8'h20;
`endif
    end

    always_comb begin
        mode_n   = mode;
        prefix_n = prefix;
        data_n   = cmd_data;
        len_n    = cmd_len;
        ovf_n    = overflow;
        last_n   = last_char;
`ifdef PS2_SHIFT_EN
        shift_n  = shift_held;
`endif
        if (mode == HOLD && cmd_ready) begin
            mode_n = COLLECT;
            data_n = '0;
            len_n  = '0;
            ovf_n  = 1'b0;
        end
        if (key_valid) begin
            case (prefix)
                PFX_BREAK: begin
                    prefix_n = PFX_NONE;
`ifdef PS2_SHIFT_EN
                    if (key_code == 8'h12 || key_code == 8'h59) shift_n = 1'b0;
`endif
                end
                PFX_EXT: prefix_n = (key_code == CODE_BREAK) ? PFX_BREAK : PFX_NONE;
                default: begin
                    if (key_code == CODE_BREAK) begin
                        prefix_n = PFX_BREAK;
                    end else if (key_code == CODE_EXT) begin
                        prefix_n = PFX_EXT;
`ifdef PS2_SHIFT_EN
                    end else if (key_code == 8'h12 || key_code == 8'h59) begin
                        shift_n = 1'b1;
`endif
                    end else if (mode == HOLD) begin
                        // A coinciding handshake has already cleared; the byte still counts as held.
                        if (dec[8]) ovf_n = 1'b1;
                    end else if (dec[8]) begin
                        if (cmd_len < LEN_W'(DEPTH)) begin
                            data_n = {cmd_data[8*DEPTH-9:0], ascii};
                            len_n  = cmd_len + LEN_W'(1);
                            last_n = ascii;
                        end else begin
                            ovf_n = 1'b1;
                        end
                    end else if (key_code == CODE_BKSP) begin
                        if (cmd_len != '0) begin
                            data_n = cmd_data >> 8;
                            len_n  = cmd_len - LEN_W'(1);
                        end
                    end else if (key_code == CODE_ESC) begin
                        data_n = '0;
                        len_n  = '0;
                    end else if (key_code == CODE_ENTER) begin
                        if (cmd_len != '0) mode_n = HOLD;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mode       <= COLLECT;
            prefix     <= PFX_NONE;
            cmd_data   <= '0;
            cmd_len    <= '0;
            overflow   <= 1'b0;
            last_char  <= 8'h00;
`ifdef PS2_SHIFT_EN
            shift_held <= 1'b0;
`endif
        end else begin
            mode       <= mode_n;
            prefix     <= prefix_n;
            cmd_data   <= data_n;
            cmd_len    <= len_n;
            overflow   <= ovf_n;
            last_char  <= last_n;
`ifdef PS2_SHIFT_EN
            shift_held <= shift_n;
`endif
        end
    end

endmodule

// File: tb/tb_ps2_command_buffer.sv
// Directed plus random bench for ps2_command_buffer against a queue-based line-editor model.
module tb_ps2_command_buffer;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset, key_valid, cmd_ready;
    logic [7:0]  key_code;
    logic        cmd_valid, overflow;
    logic [31:0] cmd_data;
    logic [2:0]  cmd_len;
    logic [7:0]  last_char;

    int errors = 0;
    int checks = 0;

    ps2_command_buffer #(.DEPTH(DEPTH), .LEN_W(3)) dut (
        .clock(clock), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .cmd_len(cmd_len), .overflow(overflow), .last_char(last_char)
    );

    always #5 clock = ~clock;

    // Reference: the command line is a queue of characters, oldest first.
    byte unsigned q[$];
    bit           m_hold, m_ovf, m_brk, m_ext, m_shift;
    byte unsigned m_last;

    byte unsigned letter_codes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
        8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
        8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    byte unsigned digit_codes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
        8'h3E, 8'h46};

    // 0 means "not printable".
    function automatic byte unsigned to_ascii(byte unsigned code, bit shift);
        for (int i = 0; i < 26; i++)
            if (letter_codes[i] == code) begin
`ifdef PS2_SHIFT_EN
                if (!shift) return byte'(8'h61 + i);
`endif
                return byte'(8'h41 + i);
            end
        for (int i = 0; i < 10; i++)
            if (digit_codes[i] == code) return byte'(8'h30 + i);
        if (code == 8'h29) return 8'h20;
        return 8'h00;
    endfunction

    task automatic model_step(bit rst, bit kv, byte unsigned code, bit rdy);
        bit was_hold;
        byte unsigned a;
        if (rst) begin
            q.delete(); m_hold = 0; m_ovf = 0; m_brk = 0; m_ext = 0; m_shift = 0; m_last = 0;
            return;
        end
        was_hold = m_hold;
        if (m_hold && rdy) begin
            m_hold = 0; q.delete(); m_ovf = 0;
        end
        if (!kv) return;
        if (m_brk) begin
            m_brk = 0;
`ifdef PS2_SHIFT_EN
            if (code == 8'h12 || code == 8'h59) m_shift = 0;
`endif
            return;
        end
        if (m_ext) begin
            m_ext = 0;
            if (code == 8'hF0) m_brk = 1;
            return;
        end
        if (code == 8'hF0) begin m_brk = 1; return; end
        if (code == 8'hE0) begin m_ext = 1; return; end
`ifdef PS2_SHIFT_EN
        if (code == 8'h12 || code == 8'h59) begin m_shift = 1; return; end
`endif
        a = to_ascii(code, m_shift);
        if (was_hold) begin
            if (a != 0) m_ovf = 1;
            return;
        end
        if (a != 0) begin
            if (q.size() < DEPTH) begin q.push_back(a); m_last = a; end
            else m_ovf = 1;
        end else if (code == 8'h66) begin
            if (q.size() > 0) void'(q.pop_back());
        end else if (code == 8'h76) begin
            q.delete();
        end else if (code == 8'h5A) begin
            if (q.size() > 0) m_hold = 1;
        end
    endtask

    function automatic logic [31:0] model_data();
        logic [31:0] d = 32'h0;
        foreach (q[i]) d = (d << 8) | 32'(q[i]);
        return d;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".valid"}, 32'(cmd_valid), 32'(m_hold));
        chk({tag, ".data"},  cmd_data, model_data());
        chk({tag, ".len"},   32'(cmd_len), 32'(q.size()));
        chk({tag, ".ovf"},   32'(overflow), 32'(m_ovf));
        chk({tag, ".last"},  32'(last_char), 32'(m_last));
    endtask

    task automatic step(string tag, bit rst, bit kv, byte unsigned code, bit rdy);
        reset = rst; key_valid = kv; key_code = code; cmd_ready = rdy;
        @(posedge clock);
        model_step(rst, kv, code, rdy);
        #1;
        check_all(tag);
    endtask

    task automatic byte_in(string tag, byte unsigned code);
        step(tag, 0, 1, code, 0);
        step(tag, 0, 0, 8'h00, 0);
    endtask

    task automatic press(string tag, byte unsigned code);
        byte_in(tag, code);
        byte_in(tag, 8'hF0);
        byte_in(tag, code);
    endtask

    initial begin
        reset = 1; key_valid = 0; key_code = 0; cmd_ready = 0;
        step("reset", 1, 0, 8'h00, 0);
        chk("reset.len0", 32'(cmd_len), 32'h0);
        chk("reset.data0", cmd_data, 32'h0);

        // F, D, commit
        press("t1", 8'h2B);
        press("t1", 8'h23);
        byte_in("t1", 8'h5A);
        chk("t1.spec_valid", 32'(cmd_valid), 32'h1);
        chk("t1.spec_data", cmd_data, 32'h0000_4644);
        byte_in("t1", 8'hF0);
        byte_in("t1", 8'h5A);
        step("t1.ack", 0, 0, 8'h00, 1);
        chk("t1.acked", 32'(cmd_valid), 32'h0);

        // fill past DEPTH, then backspace
        press("t2", 8'h1C); press("t2", 8'h32); press("t2", 8'h21);
        press("t2", 8'h23); press("t2", 8'h24);
        chk("t2.spec_data", cmd_data, 32'h4142_4344);
        chk("t2.spec_ovf", 32'(overflow), 32'h1);
        press("t2", 8'h66);
        chk("t2.spec_bksp", cmd_data, 32'h0041_4243);

        // hold with ready low, key press while held, then accept
        byte_in("t3", 8'h5A);
        for (int i = 0; i < 10; i++) step("t3.wait", 0, 0, 8'h00, 0);
        press("t3", 8'h16);
        chk("t3.spec_frozen", cmd_data, 32'h0041_4243);
        step("t3.ack", 0, 0, 8'h00, 1);
        chk("t3.spec_cleared", 32'(cmd_len), 32'h0);

        // keypad enter never commits; empty enter ignored
        press("t4", 8'h45);
        byte_in("t4", 8'hE0); byte_in("t4", 8'h5A);
        byte_in("t4", 8'hE0); byte_in("t4", 8'hF0); byte_in("t4", 8'h5A);
        chk("t4.spec_nocommit", 32'(cmd_valid), 32'h0);
        press("t4", 8'h76);
        byte_in("t4", 8'h5A);
        chk("t4.spec_empty_enter", 32'(cmd_valid), 32'h0);

        // reset while a command is held, then key + enter
        press("t5", 8'h1C);
        byte_in("t5", 8'h5A);
        step("t5.rst", 1, 0, 8'h00, 0);
        chk("t5.spec_rst_valid", 32'(cmd_valid), 32'h0);
        byte_in("t5", 8'h45); byte_in("t5", 8'h5A);
        chk("t5.spec_data", cmd_data, 32'h0000_0030);

        // coincident handshake and printable make
        step("t6.coinc", 0, 1, 8'h1C, 1);
        step("t6.idle", 0, 0, 8'h00, 0);

`ifdef PS2_SHIFT_EN
        step("sh.rst", 1, 0, 8'h00, 0);
        byte_in("sh", 8'h1C);
        chk("sh.lower", 32'(last_char), 32'h61);
        byte_in("sh", 8'h12); byte_in("sh", 8'h1C);
        chk("sh.upper", 32'(last_char), 32'h41);
        byte_in("sh", 8'hF0); byte_in("sh", 8'h12); byte_in("sh", 8'h1C);
        chk("sh.lower2", 32'(last_char), 32'h61);
`endif

        // random traffic
        begin
            byte unsigned pool[20] = '{8'h1C, 8'h32, 8'h45, 8'h16, 8'h29, 8'hF0, 8'hF0, 8'hE0,
                8'h66, 8'h76, 8'h5A, 8'h5A, 8'h12, 8'h59, 8'h2B, 8'h1A, 8'h46, 8'h0D, 8'h7E, 8'h23};
            for (int i = 0; i < 3000; i++) begin
                bit rst, kv, rdy;
                byte unsigned c;
                rst = ($urandom_range(0, 299) == 0);
                kv  = ($urandom_range(0, 1) == 1);
                rdy = ($urandom_range(0, 3) == 0);
                c   = ($urandom_range(0, 9) == 0) ? byte'($urandom_range(0, 255))
                                                 : pool[$urandom_range(0, 19)];
                step("rand", rst, kv, c, rdy);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
